// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: access widths, FSM states,
// and big-endian byte-lane masks (lane 3 = bits[31:24] = byte offset 0).
package dmem_responder_pkg;

    localparam logic [1:0] WIDTH_WORD = 2'd0;
    localparam logic [1:0] WIDTH_HALF = 2'd1;
    localparam logic [1:0] WIDTH_BYTE = 2'd2;
    localparam logic [1:0] WIDTH_ILL  = 2'd3;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    localparam logic [3:0] LANE_WORD  = 4'b1111;
    localparam logic [3:0] LANE_HALF0 = 4'b1100;
    localparam logic [3:0] LANE_BYTE0 = 4'b1000;

    // Offset is assumed already aligned for the width.
    function automatic logic [3:0] lane_mask(input logic [1:0] width, input logic [1:0] off);
        case (width)
            WIDTH_WORD: lane_mask = LANE_WORD;
            WIDTH_HALF: lane_mask = LANE_HALF0 >> off;
            WIDTH_BYTE: lane_mask = LANE_BYTE0 >> off;
            default:    lane_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational big-endian lane steering: store byte-enables/shifted data and
// load lane extraction with sign extension.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [1:0]  width_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] ld_word_i,
    output logic [3:0]  be_o,
    output logic [31:0] st_word_o,
    output logic [31:0] ld_data_o
);

    logic [4:0]  sh_b;
    logic [4:0]  sh_h;
    logic [31:0] ld_b;
    logic [31:0] ld_h;

    // Offset 0 lives in the top lane, so the shift is (3-off) bytes / (1-off/2) halves.
    assign sh_b = {~off_i, 3'b000};
    assign sh_h = {~off_i[1], 4'b0000};
    assign be_o = lane_mask(width_i, off_i);

    always_comb begin
        st_word_o = '0;
        ld_data_o = '0;
        ld_b      = ld_word_i >> sh_b;
        ld_h      = ld_word_i >> sh_h;
        case (width_i)
            WIDTH_WORD: begin
                st_word_o = st_data_i;
                ld_data_o = ld_word_i;
            end
            WIDTH_HALF: begin
                st_word_o = {16'h0000, st_data_i[15:0]} << sh_h;
                ld_data_o = {{16{ld_h[15]}}, ld_h[15:0]};
            end
            WIDTH_BYTE: begin
                st_word_o = {24'h000000, st_data_i[7:0]} << sh_b;
                ld_data_o = {{24{ld_b[7]}}, ld_b[7:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data RAM responder with programmable wait states.
// Optional macro DMEM_ALIGN_CHECK_EN: misaligned half/word accesses raise Err.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Req_Valid,
    input  logic        R_Enable,
    input  logic        W_Enable,
    input  logic [1:0]  R_Width,
    input  logic [1:0]  W_Width,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic        Req_Ready,
    output logic        Stall,
    output logic        Resp_Valid,
    output logic [31:0] ReadData,
    output logic        Err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic        rd_q, wr_q, err_q;
    logic [1:0]  rwid_q, wwid_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        in_idle, accept, enter_resp, bad;
    logic [31:0] acc_addr, acc_wdata, rd_word, st_word, ld_data;
    logic        acc_rd, acc_wr;
    logic [1:0]  acc_rwid, acc_wwid, width, off;
    logic [3:0]  be;
    logic [AW-1:0] idx;
    logic        unused_addr;

    assign in_idle   = (state_q == ST_IDLE);
    assign Req_Ready = in_idle && Rst_n;
    assign accept    = Req_Ready && Req_Valid && (R_Enable || W_Enable);

    // With zero wait states the access commits on the accept edge itself,
    // so the live request is used in IDLE and the latched one afterwards.
    assign acc_addr  = in_idle ? Address   : addr_q;
    assign acc_wdata = in_idle ? WriteData : wdata_q;
    assign acc_rd    = in_idle ? R_Enable  : rd_q;
    assign acc_wr    = in_idle ? W_Enable  : wr_q;
    assign acc_rwid  = in_idle ? R_Width   : rwid_q;
    assign acc_wwid  = in_idle ? W_Width   : wwid_q;
    assign width     = acc_wr ? acc_wwid : acc_rwid;

`ifdef DMEM_ALIGN_CHECK_EN
    logic misalign;
    assign misalign = ((width == WIDTH_HALF) && acc_addr[0]) ||
                      ((width == WIDTH_WORD) && (acc_addr[1:0] != 2'b00));
    assign bad = (acc_rd && acc_wr) || (width == WIDTH_ILL) || misalign;
    assign off = acc_addr[1:0];
`else
    assign bad = (acc_rd && acc_wr) || (width == WIDTH_ILL);
    assign off = (width == WIDTH_WORD) ? 2'b00 :
                 (width == WIDTH_HALF) ? {acc_addr[1], 1'b0} : acc_addr[1:0];
`endif

    assign idx         = acc_addr[AW+1:2];
    assign unused_addr = ^acc_addr[31:AW+2];
    assign rd_word     = mem[idx];

    assign enter_resp = Rst_n &&
                        ((in_idle && accept && (WAIT_STATES == 0)) ||
                         ((state_q == ST_WAIT) && (cnt_q == 4'd0)));

    dmem_lane_align u_align (
        .width_i   (width),
        .off_i     (off),
        .st_data_i (acc_wdata),
        .ld_word_i (rd_word),
        .be_o      (be),
        .st_word_o (st_word),
        .ld_data_o (ld_data)
    );

    always_ff @(posedge Clk) begin
        if (enter_resp && acc_wr && !bad) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= st_word[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
                cnt_d   = WS_INIT;
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rwid_q  <= '0;
            wwid_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= Address;
                wdata_q <= WriteData;
                rd_q    <= R_Enable;
                wr_q    <= W_Enable;
                rwid_q  <= R_Width;
                wwid_q  <= W_Width;
            end
            if (enter_resp) begin
                rdata_q <= (bad || acc_wr) ? 32'h0 : ld_data;
                err_q   <= bad;
            end
        end
    end

    assign Resp_Valid = (state_q == ST_RESP);
    assign Stall      = (in_idle && accept) || (state_q == ST_WAIT);
    assign ReadData   = rdata_q;
    assign Err        = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: WAIT_STATES=1 instance (a) and WAIT_STATES=0 instance (b).
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        va, vb, R_En, W_En;
    logic [1:0]  RW, WW;
    logic [31:0] Addr, WD;
    logic        a_rdy, a_stall, a_rv, a_err, b_rdy, b_stall, b_rv, b_err;
    logic [31:0] a_rd, b_rd;
    int          checks = 0;
    int          errors = 0;

    always #5 Clk = ~Clk;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) dut_a (
        .Clk(Clk), .Rst_n(Rst_n), .Req_Valid(va), .R_Enable(R_En), .W_Enable(W_En),
        .R_Width(RW), .W_Width(WW), .Address(Addr), .WriteData(WD),
        .Req_Ready(a_rdy), .Stall(a_stall), .Resp_Valid(a_rv), .ReadData(a_rd), .Err(a_err));

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut_b (
        .Clk(Clk), .Rst_n(Rst_n), .Req_Valid(vb), .R_Enable(R_En), .W_Enable(W_En),
        .R_Width(RW), .W_Width(WW), .Address(Addr), .WriteData(WD),
        .Req_Ready(b_rdy), .Stall(b_stall), .Resp_Valid(b_rv), .ReadData(b_rd), .Err(b_err));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One request; returns response data, error, latency (cycles after accept) and stall cycles.
    task automatic req(input bit sel, input logic r, input logic w, input logic [1:0] rw,
                       input logic [1:0] ww, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er, output int lat, output int stc);
        @(negedge Clk);
        R_En = r; W_En = w; RW = rw; WW = ww; Addr = a; WD = d;
        if (sel) vb = 1'b1; else va = 1'b1;
        #1 stc = int'(sel ? b_stall : a_stall);
        @(posedge Clk);
        #1 va = 1'b0; vb = 1'b0; R_En = 1'b0; W_En = 1'b0;
        lat = 0; rd = 'x; er = 1'bx;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            lat++;
            if (sel ? b_rv : a_rv) begin
                rd = sel ? b_rd : a_rd;
                er = sel ? b_err : a_err;
                break;
            end
            stc += int'(sel ? b_stall : a_stall);
        end
    endtask

    task automatic tx(input string tag, input bit sel, input logic r, input logic w,
                      input logic [1:0] rw, input logic [1:0] ww, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          lat, stc;
        req(sel, r, w, rw, ww, a, d, rd, er, lat, stc);
        chk({tag, ".lat"}, lat, sel ? 1 : 2);
        chk({tag, ".stall"}, stc, sel ? 1 : 2);
        chk({tag, ".data"}, rd, exp_rd);
        chk({tag, ".err"}, {31'b0, er}, {31'b0, exp_err});
    endtask

    initial begin
        Rst_n = 1'b0; va = 0; vb = 0; R_En = 0; W_En = 0; RW = 0; WW = 0; Addr = 0; WD = 0;
        #12;
        chk("rst.ready", a_rdy, 0);
        chk("rst.stall", a_stall, 0);
        chk("rst.rv", a_rv, 0);
        chk("rst.rdata", a_rd, 0);
        chk("rst.err", a_err, 0);
        @(negedge Clk) Rst_n = 1'b1;
        #1 chk("rel.ready", a_rdy, 1);

        tx("sw10", 0, 0, 1, 0, WIDTH_WORD, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        tx("lw10", 0, 1, 0, WIDTH_WORD, 0, 32'h10, 0, 32'hDEADBEEF, 0);
        @(negedge Clk) chk("hold.rdata", a_rd, 32'hDEADBEEF);
        tx("lwwrap", 0, 1, 0, WIDTH_WORD, 0, 32'h1010, 0, 32'hDEADBEEF, 0);

        tx("sw20", 0, 0, 1, 0, WIDTH_WORD, 32'h20, 32'h80FF7F01, 32'h0, 0);
        tx("lb20", 0, 1, 0, WIDTH_BYTE, 0, 32'h20, 0, 32'hFFFFFF80, 0);
        tx("lb23", 0, 1, 0, WIDTH_BYTE, 0, 32'h23, 0, 32'h00000001, 0);
        tx("lb22", 0, 1, 0, WIDTH_BYTE, 0, 32'h22, 0, 32'h0000007F, 0);
        tx("lh20", 0, 1, 0, WIDTH_HALF, 0, 32'h20, 0, 32'hFFFF80FF, 0);
        tx("lh22", 0, 1, 0, WIDTH_HALF, 0, 32'h22, 0, 32'h00007F01, 0);

        tx("sw40", 0, 0, 1, 0, WIDTH_WORD, 32'h40, 32'h11223344, 32'h0, 0);
        tx("sb41", 0, 0, 1, 0, WIDTH_BYTE, 32'h41, 32'h000000AA, 32'h0, 0);
        tx("lw40a", 0, 1, 0, WIDTH_WORD, 0, 32'h40, 0, 32'h11AA3344, 0);
        tx("sh42", 0, 0, 1, 0, WIDTH_HALF, 32'h42, 32'h0000BEEF, 32'h0, 0);
        tx("lw40b", 0, 1, 0, WIDTH_WORD, 0, 32'h40, 0, 32'h11AABEEF, 0);

        tx("rwboth", 0, 1, 1, WIDTH_WORD, WIDTH_WORD, 32'h40, 32'h0, 32'h0, 1);
        tx("lw40c", 0, 1, 0, WIDTH_WORD, 0, 32'h40, 0, 32'h11AABEEF, 0);
        tx("rwid3", 0, 1, 0, WIDTH_ILL, 0, 32'h40, 0, 32'h0, 1);
        tx("wwid3", 0, 0, 1, 0, WIDTH_ILL, 32'h40, 32'h0, 32'h0, 1);
        tx("lw40d", 0, 1, 0, WIDTH_WORD, 0, 32'h40, 0, 32'h11AABEEF, 0);

`ifdef DMEM_ALIGN_CHECK_EN
        tx("lw11", 0, 1, 0, WIDTH_WORD, 0, 32'h11, 0, 32'h0, 1);
        tx("lh21", 0, 1, 0, WIDTH_HALF, 0, 32'h21, 0, 32'h0, 1);
`else
        tx("lw11", 0, 1, 0, WIDTH_WORD, 0, 32'h11, 0, 32'hDEADBEEF, 0);
        tx("lh21", 0, 1, 0, WIDTH_HALF, 0, 32'h21, 0, 32'hFFFF80FF, 0);
`endif

        // Valid with no enable is not an access.
        @(negedge Clk) va = 1'b1;
        #1 chk("noen.stall", a_stall, 0);
        @(posedge Clk) #1 va = 1'b0;
        @(negedge Clk) chk("noen.rv", a_rv, 0);

        // Reset during WAIT of a store aborts it.
        tx("sw30", 0, 0, 1, 0, WIDTH_WORD, 32'h30, 32'h5555AAAA, 32'h0, 0);
        @(negedge Clk);
        W_En = 1; WW = WIDTH_WORD; Addr = 32'h30; WD = 32'hBADBAD00; va = 1'b1;
        @(posedge Clk) #1 va = 1'b0; W_En = 1'b0;
        #1 chk("mid.stall_wait", a_stall, 1);
        #1 Rst_n = 1'b0;
        #1 chk("mid.ready", a_rdy, 0);
        chk("mid.stall", a_stall, 0);
        chk("mid.rdata", a_rd, 0);
        begin
            int seen = 0;
            for (int i = 0; i < 3; i++) begin
                @(negedge Clk);
                seen += int'(a_rv);
            end
            @(negedge Clk) Rst_n = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge Clk);
                seen += int'(a_rv);
            end
            chk("mid.no_rv", seen, 0);
        end
        tx("lw30", 0, 1, 0, WIDTH_WORD, 0, 32'h30, 0, 32'h5555AAAA, 0);

        tx("b.sw08", 1, 0, 1, 0, WIDTH_WORD, 32'h08, 32'h12345678, 32'h0, 0);
        tx("b.lw08", 1, 1, 0, WIDTH_WORD, 0, 32'h08, 0, 32'h12345678, 0);
        tx("b.lb0b", 1, 1, 0, WIDTH_BYTE, 0, 32'h0B, 0, 32'h00000078, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
